bmem_arbiter: RTL and testbench

// - Shares the single burst-memory port (bmem_*) between the I-cache and D-cache line-fill/writeback paths.
// - Picks one client request, captures its address (and write line), and runs one BURST_LEN-beat burst.
// - Returns a full cache line with a one-cycle resp pulse. Sits in mp4 between the two caches and the bmem pins.

---
 rtl/bmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one burst-memory port between I-cache line fills and D-cache fills/writebacks.
// Build option: define BMEM_ARB_DPRIO_EN for fixed D-side priority instead of round-robin.
module bmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic                        i_read,
    output logic [DATA_W*BURST_LEN-1:0] i_rdata,
    output logic                        i_resp,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [DATA_W*BURST_LEN-1:0] d_wdata,
    output logic [DATA_W*BURST_LEN-1:0] d_rdata,
    output logic                        d_resp,
    output logic [ADDR_W-1:0]           bmem_address,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [DATA_W-1:0]           bmem_wdata,
    input  logic [DATA_W-1:0]           bmem_rdata,
    input  logic                        bmem_resp
);
    localparam int LINE_W = DATA_W * BURST_LEN;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    beat;
    logic                owner_d;
    logic                just_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wline;
    logic [LINE_W-1:0]   rline;
    logic [LINE_W-1:0]   line_fill;
    logic                req_i;
    logic                req_d;
    logic                grant;
    logic                grant_d;
    logic                last_beat;
    logic [ADDR_W-1:0]   grant_addr;
`ifdef BMEM_ARB_DPRIO_EN
`else
    logic                rr;
`endif

    // The side served last is masked for one IDLE cycle so its lagging request is not re-granted.
    always_comb begin
        req_i = i_read && !(just_done && !owner_d);
        req_d = (d_read || d_write) && !(just_done && owner_d);
        grant = req_i || req_d;
`ifdef BMEM_ARB_DPRIO_EN
        grant_d = req_d;
`else
        grant_d = req_d && (!req_i || rr);
`endif
        grant_addr = (grant_d ? d_addr : i_addr) & ~OFF_MASK;
        last_beat  = (beat == LAST_BEAT);
        line_fill  = rline;
        line_fill[int'(beat)*DATA_W +: DATA_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_n = (grant_d && d_write) ? WR : RD;
                end
            end
            RD, WR: begin
                if (bmem_resp && last_beat) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bmem_read    = (state == RD);
        bmem_write   = (state == WR);
        bmem_address = addr_q;
        bmem_wdata   = '0;
        if (state == WR) begin
            bmem_wdata = wline[int'(beat)*DATA_W +: DATA_W];
        end
        i_resp = (state == DONE) && !owner_d;
        d_resp = (state == DONE) && owner_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            owner_d   <= 1'b0;
            just_done <= 1'b0;
            addr_q    <= '0;
            wline     <= '0;
            rline     <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef BMEM_ARB_DPRIO_EN
`else
            rr        <= 1'b0;
`endif
        end else begin
            just_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_addr;
                        beat    <= '0;
                        if (grant_d && d_write) begin
                            wline <= d_wdata;
                        end
`ifdef BMEM_ARB_DPRIO_EN
`else
                        rr <= !grant_d;
`endif
                    end
                end
                RD: begin
                    if (bmem_resp) begin
                        rline <= line_fill;
                        beat  <= last_beat ? '0 : beat + 1'b1;
                        // Completed line is published at the last beat so rdata is valid during DONE.
                        if (last_beat) begin
                            if (owner_d) begin
                                d_rdata <= line_fill;
                            end else begin
                                i_rdata <= line_fill;
                            end
                        end
                    end
                end
                WR: begin
                    if (bmem_resp) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: directed scenarios plus randomized rounds checked against a
// transaction-level model of grant order, burst address/data and returned lines.
`timescale 1ns/1ps
module tb_bmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int LW = DW * BL;
    localparam logic [AW-1:0] LINE_MASK = ~32'h0000_001F;
    localparam logic [LW-1:0] A_LINE = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                                        64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    localparam logic [LW-1:0] W_LINE = {64'hD3D3_5555_0000_0033, 64'hD2D2_6666_0000_0022,
                                        64'hD1D1_7777_0000_0011, 64'hD0D0_8888_0000_0000};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr;
    logic          i_read;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] bmem_address;
    logic          bmem_read;
    logic          bmem_write;
    logic [DW-1:0] bmem_wdata;
    logic [DW-1:0] bmem_rdata;
    logic          bmem_resp;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          pref_d;
    logic [LW-1:0] last_i;
    logic [LW-1:0] last_d;

    bmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; bmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pref_d = 1'b0; last_i = '0; last_d = '0;
    endtask

    // Serves one burst as the memory; returns at the negedge of the expected resp cycle.
    task automatic run_burst(input bit is_d, input bit is_wr, input logic [AW-1:0] exp_addr,
                             input logic [LW-1:0] wl, input int minw, input int maxw,
                             input bit use_fixed, input logic [LW-1:0] fixed_line,
                             output logic [LW-1:0] rl, output bit ok);
        int guard;
        int nw;
        logic [DW-1:0] bv;
        guard = 0; ok = 1'b1; rl = '0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bmem_read || bmem_write) && guard < 40);
        if (!(bmem_read || bmem_write)) begin
            check("grant_timeout", bmem_read || bmem_write, 1);
            ok = 1'b0;
            return;
        end
        check("op", {bmem_read, bmem_write}, {!is_wr, is_wr});
        check("addr", bmem_address, exp_addr);
        if (is_d) begin
            d_addr = $urandom; d_wdata = rand_line();
        end else begin
            i_addr = $urandom;
        end
        for (int b = 0; b < BL; b++) begin
            nw = $urandom_range(maxw, minw);
            repeat (nw) begin
                @(negedge clk);
                check("strobe_hold", {bmem_read, bmem_write}, {!is_wr, is_wr});
                check("addr_hold", bmem_address, exp_addr);
            end
            bv = use_fixed ? fixed_line[b*DW +: DW] : {$urandom, $urandom};
            rl[b*DW +: DW] = bv;
            if (is_wr) check("wdata", bmem_wdata, wl[b*DW +: DW]);
            bmem_rdata = bv; bmem_resp = 1'b1;
            @(negedge clk);
            bmem_resp = 1'b0; bmem_rdata = {$urandom, $urandom};
            if (b < BL - 1) check("strobe_mid", {bmem_read, bmem_write}, {!is_wr, is_wr});
        end
        check("strobe_drop", {bmem_read, bmem_write}, 2'b00);
        check("resp", {i_resp, d_resp}, {!is_d, is_d});
        if (!is_wr) begin
            if (is_d) last_d = rl;
            else last_i = rl;
        end
        check("i_rdata", i_rdata, last_i);
        check("d_rdata", d_rdata, last_d);
    endtask

    // Client side after resp: optional extra cycle of stale request, then drop.
    task automatic finish_txn(input bit is_d, input bit other_pending, input bit late_drop);
        @(negedge clk);
        check("resp_pulse", {i_resp, d_resp}, 2'b00);
        if (late_drop) @(negedge clk);
        if (is_d) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        if (!other_pending) check("no_regrant", {bmem_read, bmem_write}, 2'b00);
    endtask

    // mode: 0 I only, 1 D only, 2 both. dop: 0 read, 1 write, 2 read+write.
    task automatic do_round(input int mode, input int dop, input int minw, input int maxw);
        bit want_i, want_d, d_wr, first_d, cur_d, ok;
        logic [AW-1:0] ai, ad;
        logic [LW-1:0] wl, rl;
        int n_grants;
        want_i = (mode != 1); want_d = (mode != 0); d_wr = (dop != 0);
        ai = $urandom; ad = $urandom; wl = rand_line();
        i_addr = ai; d_addr = ad; d_wdata = wl;
        i_read = want_i;
        d_read = want_d && (dop != 1);
        d_write = want_d && (dop != 0);
        if (want_i && want_d) begin
`ifdef BMEM_ARB_DPRIO_EN
            first_d = 1'b1;
`else
            first_d = pref_d;
`endif
        end else begin
            first_d = want_d;
        end
        n_grants = (want_i && want_d) ? 2 : 1;
        for (int k = 0; k < n_grants; k++) begin
            cur_d = (k == 0) ? first_d : !first_d;
            pref_d = !cur_d;
            run_burst(cur_d, cur_d && d_wr, (cur_d ? ad : ai) & LINE_MASK, wl, minw, maxw,
                      1'b0, '0, rl, ok);
            if (!ok) begin
                apply_reset();
                return;
            end
            finish_txn(cur_d, (k == 0) && (n_grants == 2), 1'($urandom_range(0, 1)));
        end
        repeat ($urandom_range(1, 3)) begin
            bmem_resp = 1'($urandom_range(0, 1));
            bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            check("idle_quiet", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        end
        bmem_resp = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] rl;
        bit ok;
        int unsigned t0;
        int guard;
        rst_n = 1'b0;
        i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_wdata = '0; bmem_rdata = '0; bmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        check("rst_addr", bmem_address, 0);
        check("rst_wdata", bmem_wdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1; pref_d = 1'b0; last_i = '0; last_d = '0;

        // Lone I read, zero-wait memory, fixed beats
        i_addr = 32'h0000_1004; i_read = 1'b1; t0 = cyc;
        pref_d = 1'b1;
        run_burst(1'b0, 1'b0, 32'h0000_1000, '0, 0, 0, 1'b1, A_LINE, rl, ok);
        check("i_latency", cyc - t0 + 1, BL + 2);
        check("i_line_fixed", i_rdata, A_LINE);
        finish_txn(1'b0, 1'b0, 1'b0);

        // Lone D write, zero-wait memory, fixed line
        d_addr = 32'h0000_2020; d_wdata = W_LINE; d_write = 1'b1;
        pref_d = 1'b0;
        run_burst(1'b1, 1'b1, 32'h0000_2020, W_LINE, 0, 0, 1'b0, '0, rl, ok);
        finish_txn(1'b1, 1'b0, 1'b0);

        // Simultaneous I and D reads straight after reset
        apply_reset();
        do_round(2, 0, 0, 0);

        // Three wait cycles before every beat
        do_round(0, 0, 3, 3);
        do_round(1, 1, 3, 3);

        // Reset during beat 2 of a D read
        d_addr = 32'h0000_3040; d_read = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bmem_read && guard < 40);
        check("abort_grant", bmem_read, 1);
        bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        bmem_resp = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        check("abort_addr", bmem_address, 0);
        check("abort_d_rdata", d_rdata, 0);
        d_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; pref_d = 1'b0; last_i = '0; last_d = '0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", {i_resp, d_resp, bmem_read}, 3'b000);
        end
        do_round(1, 0, 0, 1);

        // Read+write together with address change mid-burst
        do_round(1, 2, 0, 2);

        repeat (40) do_round($urandom_range(0, 2), $urandom_range(0, 2), 0, $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
